router_output_arbiter: RTL

- Wormhole, credit-based arbiter that shares one router output channel between NUM_PORTS input queues.
- Grants one packet at a time using round-robin over head flits, then holds the output for the owner until that packet's tail flit.
- Drives the registered output channel that feeds router_slice's CHANNEL_IN_IP.
- Consumes downstream credit returns on FLOW_CTRL_IN_OP.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_output_arbiter_rr_arbiter.sv | 35 +++
 rtl/router_output_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: flit field layout, flow-control bits, arbiter states.
package router_pkg;

  localparam int unsigned ROUTER_FLIT_W = 68;

  // Flit field bit positions
  localparam int unsigned FLIT_VALID       = 0;
  localparam int unsigned FLIT_HEAD        = 1;
  localparam int unsigned FLIT_TAIL        = 2;
  localparam int unsigned FLIT_PAYLOAD_LSB = 3;

  // Flow-control input bit carrying a returned credit
  localparam int unsigned FLOW_CTRL_CREDIT = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/router_output_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr,
  output logic [NUM_PORTS-1:0]         gnt,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_idx
);

  localparam int unsigned IW = $clog2(NUM_PORTS);

  logic        w_found;
  int unsigned w_idx;

  // Scan ports starting at rr_ptr, first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_idx = 32'(rr_ptr) + i;
      if (w_idx >= NUM_PORTS) begin
        w_idx = w_idx - NUM_PORTS;
      end
      if (!w_found && req[IW'(w_idx)]) begin
        w_found          = 1'b1;
        gnt[IW'(w_idx)]  = 1'b1;
        gnt_idx          = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Wormhole credit-based output arbiter: round-robin packet grant, lock to tail.
module router_output_arbiter
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned FLIT_W    = ROUTER_FLIT_W,
  parameter int unsigned CREDITS   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS*FLIT_W-1:0]    in_flit,
  input  logic [NUM_PORTS-1:0]           in_valid,
  output logic [NUM_PORTS-1:0]           in_pop,
  input  logic [0:1]                     FLOW_CTRL_IN_OP,
  output logic [0:FLIT_W-1]              CHANNEL_OUT_OP,
  output logic [$clog2(NUM_PORTS)-1:0]   grant_id,
  output logic [$clog2(CREDITS+1)-1:0]   credit_count,
  output logic                           ERROR
);

  localparam int unsigned GW = $clog2(NUM_PORTS);
  localparam int unsigned CW = $clog2(CREDITS+1);

  arb_state_t          r_state;
  logic [GW-1:0]       r_rr_ptr;
  logic [GW-1:0]       r_grant_id;
  logic [CW-1:0]       r_credit;
  logic [0:FLIT_W-1]   r_chan;
  logic                r_error;

  logic [FLIT_W-1:0]   w_flit [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_nonhead;
  logic [NUM_PORTS-1:0] w_arb_gnt;
  logic [GW-1:0]       w_arb_idx;
  logic                w_sel;
  logic [GW-1:0]       w_sel_idx;
  logic                w_send;
  logic                w_proto_err;
  logic [FLIT_W-1:0]   w_out_flit;
  logic [0:FLIT_W-1]   w_out_chan;
  logic                w_tail;
  logic [GW-1:0]       w_next_ptr;
  logic                w_ret;
  logic                w_overflow;
  logic                w_unused_fc;

  // Slice per-port flits and classify head/non-head requests
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign w_flit[g]    = in_flit[g*FLIT_W +: FLIT_W];
    assign w_req[g]     = in_valid[g] & w_flit[g][FLIT_HEAD];
    assign w_nonhead[g] = in_valid[g] & ~w_flit[g][FLIT_HEAD];
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arbiter (
    .req     (w_req),
    .rr_ptr  (r_rr_ptr),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx)
  );

  assign w_ret       = FLOW_CTRL_IN_OP[FLOW_CTRL_CREDIT];
  assign w_unused_fc = FLOW_CTRL_IN_OP[1] ^ (|w_arb_gnt);

  // Select source port, decide on a send, build the forwarded flit
  always_comb begin
    w_sel       = 1'b0;
    w_sel_idx   = r_grant_id;
    w_proto_err = 1'b0;
    if (r_state == IDLE) begin
      w_sel       = |w_req;
      w_sel_idx   = w_arb_idx;
      w_proto_err = |w_nonhead;
    end else begin
      w_sel       = in_valid[r_grant_id];
      w_proto_err = in_valid[r_grant_id] & w_flit[r_grant_id][FLIT_HEAD];
    end
    w_send = w_sel & (r_credit != '0);

    w_out_flit             = w_flit[w_sel_idx];
    w_out_flit[FLIT_VALID] = 1'b1;
    w_tail                 = w_out_flit[FLIT_TAIL];
    for (int unsigned i = 0; i < FLIT_W; i++) begin
      w_out_chan[i] = w_out_flit[i];
    end

    in_pop = '0;
    if (w_send) begin
      in_pop[w_sel_idx] = 1'b1;
    end

    w_next_ptr = (w_sel_idx == GW'(NUM_PORTS-1)) ? '0 : w_sel_idx + GW'(1);
    w_overflow = w_ret & ~w_send & (r_credit == CW'(CREDITS));
  end

  // FSM, credit counter, output channel and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_credit   <= CW'(CREDITS);
      r_chan     <= '0;
      r_error    <= 1'b0;
    end else begin
      r_error <= r_error | w_proto_err | w_overflow;
      r_chan  <= w_send ? w_out_chan : '0;

      if (w_send && !w_ret) begin
        r_credit <= r_credit - CW'(1);
      end else if (!w_send && w_ret && !w_overflow) begin
        r_credit <= r_credit + CW'(1);
      end

      if (w_send) begin
        r_grant_id <= w_sel_idx;
        if (w_tail) begin
          r_state  <= IDLE;
          r_rr_ptr <= w_next_ptr;
        end else begin
          r_state  <= LOCKED;
        end
      end
    end
  end

  assign CHANNEL_OUT_OP = r_chan;
  assign grant_id       = r_grant_id;
  assign credit_count   = r_credit;
  assign ERROR          = r_error;

endmodule
